id_operand_issue: RTL

- Parametrised decode/issue register slice for the 5-stage pipeline, sitting between IF and EXE.
- Latches an already-decoded instruction payload with its source register numbers, then drives the regfile read addresses.
- Resolves each source operand through a priority forwarding network fed by NUM_FWD younger producer stages, and stalls when the selected producer's data is not yet available (load, multi-cycle mul/div).
- Successor to the fixed two-source, EXE-load-only interlock: any source count, any producer depth, per-producer data-ready, flush, and a stall performance counter.

---
 rtl/id_operand_issue_pkg.sv | 22 ++
 rtl/id_operand_issue_if.sv | 32 +++
 rtl/id_operand_issue_fwd_select.sv | 62 ++++++
 rtl/id_operand_issue.sv | 95 +++++++++
 4 files changed

// File: rtl/id_operand_issue_pkg.sv
// Shared constants and types for the decode/issue operand slice.
package id_operand_issue_pkg;

    // Register-number width of the integer regfile.
    localparam int unsigned REG_ADDR_W = 5;

    // Producer indices on the forwarding buses; lower index is younger.
    localparam int unsigned FWD_EXE = 0;
    localparam int unsigned FWD_MEM = 1;
    localparam int unsigned FWD_WB  = 2;

    // Default width of the opaque decoded payload (control bits plus pc).
    localparam int unsigned PAYLOAD_W_DFLT = 160;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Width of a packed bus carrying n register numbers.
    function automatic int unsigned addr_bus_w(input int unsigned n);
        return n * REG_ADDR_W;
    endfunction

endpackage

// File: rtl/id_operand_issue_if.sv
// Upstream (IF->ID) and downstream (ID->EXE) handshake bundle of the issue slice.
interface id_operand_issue_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned PAYLOAD_W = 160
);
    import id_operand_issue_pkg::*;

    logic                              in_valid;
    logic                              in_allowin;
    logic [PAYLOAD_W-1:0]              in_payload;
    logic [NUM_SRC-1:0]                in_src_en;
    logic [addr_bus_w(NUM_SRC)-1:0]    in_src_addr;

    logic                              out_valid;
    logic                              out_allowin;
    logic [PAYLOAD_W-1:0]              out_payload;
    logic [NUM_SRC*XLEN-1:0]           out_src_data;

    // Environment side: feeds instructions and accepts the issued ones.
    modport master (
        output in_valid, in_payload, in_src_en, in_src_addr, out_allowin,
        input  in_allowin, out_valid, out_payload, out_src_data
    );

    // Issue slice side.
    modport slave (
        input  in_valid, in_payload, in_src_en, in_src_addr, out_allowin,
        output in_allowin, out_valid, out_payload, out_src_data
    );

endinterface

// File: rtl/id_operand_issue_fwd_select.sv
// Per-source operand resolver: priority forwarding select plus data-ready hazard.
module fwd_select
    import id_operand_issue_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 3
) (
    input  logic                          valid,
    input  logic                          src_en,
    input  reg_addr_t                     src_addr,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_we,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    input  logic [NUM_FWD-1:0]            fwd_data_ok,
    input  logic [XLEN-1:0]               rf_rdata,
    output logic [XLEN-1:0]               data,
    output logic                          hazard
);

    logic               live;
    logic [NUM_FWD-1:0] match;
    logic [NUM_FWD-1:0] first;
    logic [NUM_FWD:0]   taken;
    logic [XLEN-1:0]    sel_data;

    // r0 and unused sources never forward and never stall.
    assign live     = valid & src_en & (src_addr != '0);
    assign taken[0] = 1'b0;

    // Priority chain from the youngest producer: first[f] marks the single winner.
    for (genvar f = 0; f < NUM_FWD; f++) begin : g_prio
        assign match[f]   = live & fwd_valid[f] & fwd_we[f] &
                            (fwd_addr[f*REG_ADDR_W +: REG_ADDR_W] == src_addr);
        assign first[f]   = match[f] & ~taken[f];
        assign taken[f+1] = taken[f] | match[f];
    end

    // A winner whose result is not final blocks issue, even if an older stage matches.
    assign hazard = |(first & ~fwd_data_ok);

    // One-hot AND-OR mux of the winning producer's result.
    always_comb begin
        sel_data = '0;
        for (int unsigned f = 0; f < NUM_FWD; f++) begin
            if (first[f]) begin
                sel_data = sel_data | fwd_data[f*XLEN +: XLEN];
            end
        end
    end

    // Operand value: zero for r0/unused, else forwarded result, else regfile.
    always_comb begin
        data = rf_rdata;
        if (!src_en || (src_addr == '0)) begin
            data = '0;
        end else if (taken[NUM_FWD]) begin
            data = sel_data;
        end
    end

endmodule

// File: rtl/id_operand_issue.sv
// Decode/issue register slice between IF and EXE with forwarding and load-use interlock.
module id_operand_issue
    import id_operand_issue_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned NUM_FWD   = 3,
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DFLT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    id_operand_issue_if.slave             pipe,
    output logic [NUM_SRC*REG_ADDR_W-1:0] rf_raddr,
    input  logic [NUM_SRC*XLEN-1:0]       rf_rdata,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_we,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    input  logic [NUM_FWD-1:0]            fwd_data_ok,
    input  logic                          flush,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                          valid_r;
    logic [PAYLOAD_W-1:0]          payload_r;
    logic [NUM_SRC-1:0]            src_en_r;
    logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_r;

    logic [NUM_SRC-1:0]            hazard;
    logic [NUM_SRC*XLEN-1:0]       src_data;
    logic                          ready_go;
    logic                          accept;

    // One resolver per source operand, all fed by the same producer buses.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_select #(
            .XLEN    (XLEN),
            .NUM_FWD (NUM_FWD)
        ) u_fwd_select (
            .valid       (valid_r),
            .src_en      (src_en_r[i]),
            .src_addr    (src_addr_r[i*REG_ADDR_W +: REG_ADDR_W]),
            .fwd_valid   (fwd_valid),
            .fwd_we      (fwd_we),
            .fwd_addr    (fwd_addr),
            .fwd_data    (fwd_data),
            .fwd_data_ok (fwd_data_ok),
            .rf_rdata    (rf_rdata[i*XLEN +: XLEN]),
            .data        (src_data[i*XLEN +: XLEN]),
            .hazard      (hazard[i])
        );
    end

    assign ready_go          = ~|hazard;
    assign pipe.in_allowin   = ~valid_r | (ready_go & pipe.out_allowin);
    assign pipe.out_valid    = valid_r & ready_go & ~flush;
    assign pipe.out_payload  = payload_r;
    assign pipe.out_src_data = src_data;
    assign rf_raddr          = src_addr_r;
    assign accept            = pipe.in_valid & pipe.in_allowin & ~flush;

    // Stage registers: flush kills the held instruction and drops any incoming one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_r    <= 1'b0;
            payload_r  <= '0;
            src_en_r   <= '0;
            src_addr_r <= '0;
        end else begin
            if (flush) begin
                valid_r <= 1'b0;
            end else if (pipe.in_allowin) begin
                valid_r <= pipe.in_valid;
            end
            if (accept) begin
                payload_r  <= pipe.in_payload;
                src_en_r   <= pipe.in_src_en;
                src_addr_r <= pipe.in_src_addr;
            end
        end
    end

    // Saturating count of cycles lost to operand hazards (back-pressure excluded).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (valid_r && !ready_go && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule
